// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if: instruction-memory fetch handshake between the IF stage
// (master) and instruction memory (slave).
//   imem_req_87    master -> slave  fetch request
//   imem_addr_87   master -> slave  fetch address (word aligned PC)
//   imem_rdata_87  slave -> master  fetched word, meaningful when ack=1
//   imem_ack_87    slave -> master  data returned for the address this cycle
// ---------------------------------------------------------------------------
interface if_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_87;
    logic [ADDR_WIDTH-1:0] imem_addr_87;
    logic [DATA_WIDTH-1:0] imem_rdata_87;
    logic                  imem_ack_87;

    modport master (
        output imem_req_87,
        output imem_addr_87,
        input  imem_rdata_87,
        input  imem_ack_87
    );

    modport slave (
        input  imem_req_87,
        input  imem_addr_87,
        output imem_rdata_87,
        output imem_ack_87
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, issues fetches over the imem handshake, and presents the
// fetched instruction, its PC+4 and a valid bit to the ID stage.
//
// Ports:
//   clk_87, rst_87         clock, synchronous active-low reset
//   stall_87, flush_87     hazard control: hold / bubble the IF/ID register
//   redirect_87,
//   redirect_pc_87         taken branch/jump from EX and its target
//   imem                   fetch handshake (master side)
//   instr_if_id_87,
//   pc4_if_id_87,
//   valid_if_id_87         IF/ID register contents
//   r1_id_87, r2_id_87     rs/rt fields of IF/ID, forced to 0 for bubbles
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                  clk_87,
    input  logic                  rst_87,
    input  logic                  stall_87,
    input  logic                  flush_87,
    input  logic                  redirect_87,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_87,
    if_stage_if.master            imem,
    output logic [DATA_WIDTH-1:0] instr_if_id_87,
    output logic [ADDR_WIDTH-1:0] pc4_if_id_87,
    output logic                  valid_if_id_87,
    output logic [4:0]            r1_id_87,
    output logic [4:0]            r2_id_87
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  req_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [ADDR_WIDTH-1:0] pc4_reg;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] skid_instr_reg;
    logic [ADDR_WIDTH-1:0] skid_pc4_reg;
    logic                  skid_valid_reg;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Natural wrap at 2^ADDR_WIDTH is the intended PC behaviour.
    assign pc_plus4         = pc_reg + ADDR_WIDTH'(4);
    assign redirect_aligned = {redirect_pc_87[ADDR_WIDTH-1:2], 2'b00};

    // Low target bits are discarded by word alignment.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc_87[1:0]};

    always_ff @(posedge clk_87) begin
        if (!rst_87) begin
            state_reg      <= BOOT;
            req_reg        <= 1'b0;
            pc_reg         <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            pc4_reg        <= '0;
            valid_reg      <= 1'b0;
            skid_instr_reg <= NOP_INSTR;
            skid_pc4_reg   <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    // Hazard and redirect inputs are meaningless before the
                    // first fetch, so BOOT ignores them.
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                end
                default: begin
                    if (redirect_87) begin
                        // Any same-cycle ack belongs to the wrong path.
                        pc_reg         <= redirect_aligned;
                        instr_reg      <= NOP_INSTR;
                        valid_reg      <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= FETCH;
                        req_reg        <= 1'b1;
                    end else if (flush_87) begin
                        // PC holds, so the dropped word is fetched again.
                        instr_reg      <= NOP_INSTR;
                        valid_reg      <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= FETCH;
                        req_reg        <= 1'b1;
                    end else if (state_reg == HELD) begin
                        if (!stall_87 && skid_valid_reg) begin
                            instr_reg      <= skid_instr_reg;
                            pc4_reg        <= skid_pc4_reg;
                            valid_reg      <= 1'b1;
                            pc_reg         <= pc_plus4;
                            skid_valid_reg <= 1'b0;
                            state_reg      <= FETCH;
                            req_reg        <= 1'b1;
                        end
                    end else if (stall_87) begin
                        // Memory already answered; park the word until ID
                        // can take it instead of asking for it again.
                        if (imem.imem_ack_87) begin
                            skid_instr_reg <= imem.imem_rdata_87;
                            skid_pc4_reg   <= pc_plus4;
                            skid_valid_reg <= 1'b1;
                            state_reg      <= HELD;
                            req_reg        <= 1'b0;
                        end
                    end else if (imem.imem_ack_87) begin
                        instr_reg <= imem.imem_rdata_87;
                        pc4_reg   <= pc_plus4;
                        valid_reg <= 1'b1;
                        pc_reg    <= pc_plus4;
                    end else begin
                        // Waiting on memory: emit a bubble, keep pc4.
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Request and address come only from registers, never from hazard inputs.
    assign imem.imem_req_87  = req_reg;
    assign imem.imem_addr_87 = pc_reg;

    assign instr_if_id_87 = instr_reg;
    assign pc4_if_id_87   = pc4_reg;
    assign valid_if_id_87 = valid_reg;

    // Bubbles report register 0 so they cannot raise a false hazard.
    assign r1_id_87 = valid_reg ? instr_reg[25:21] : 5'd0;
    assign r2_id_87 = valid_reg ? instr_reg[20:16] : 5'd0;

endmodule
